// File: rtl/memory_game_pkg.sv
// Shared widths, limits and the display state encoding for the memory game.
// Imported by the sequence display and by the feedback and player-input logic.
package memory_game_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 4;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int IDX_W   = 5;
    localparam int TIMER_W = 27;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHOW,
        GAP
    } display_state_t;

    // Requested lengths above MAX_LEN play the whole sequence memory.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/sequence_display_if.sv
// Control, sequence-memory and LED signals of the sequence display.
// The block itself takes the slave side; the game controller takes the master side.
interface sequence_display_if;
    import memory_game_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] bram_data;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] leds;
    logic              busy;
    logic              done;

    modport master (
        output start, length, bram_data,
        input  addr, leds, busy, done
    );

    modport slave (
        input  start, length, bram_data,
        output addr, leds, busy, done
    );

endinterface

// File: rtl/dwell_timer.sv
// Saturating dwell counter: expired is high once terminal+1 cycles have elapsed
// since the last clear, and stays high until the next clear.
module dwell_timer
    import memory_game_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [TIMER_W-1:0] terminal,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    assign expired = (count == terminal);

    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/sequence_display.sv
// Plays the first `length` entries of the sequence memory on the LEDs,
// each shown for SHOW_CYCLES and followed by GAP_CYCLES of blank.
module sequence_display
    import memory_game_pkg::*;
#(
    parameter int SHOW_CYCLES = 62_500_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic               clk,
    input  logic               rst,
    sequence_display_if.slave  bus
);

    localparam logic [TIMER_W-1:0] SHOW_TC = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_TC  = TIMER_W'(GAP_CYCLES - 1);

    display_state_t     state, next_state;
    logic [IDX_W-1:0]   index;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   start_len;
    logic               last_elem;
    logic               timer_clear;
    logic               timer_expired;
    logic [TIMER_W-1:0] timer_tc;

    assign start_len = clamp_len(bus.length);
    assign last_elem = (index == len_q - LEN_W'(1));

    dwell_timer u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .terminal (timer_tc),
        .expired  (timer_expired)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state  = state;
        timer_clear = 1'b1;
        timer_tc    = SHOW_TC;
        case (state)
            IDLE:  if (bus.start && start_len != '0) next_state = FETCH;
            FETCH: next_state = LOAD;
            LOAD:  next_state = SHOW;
            SHOW: begin
                timer_clear = timer_expired;
                if (timer_expired) next_state = GAP;
            end
            GAP: begin
                timer_tc    = GAP_TC;
                timer_clear = timer_expired;
                if (timer_expired) next_state = last_elem ? IDLE : FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    // The address for an element is registered on the edge entering FETCH,
    // so the memory sees it during FETCH and returns data during LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index    <= '0;
            len_q    <= '0;
            bus.addr <= '0;
            bus.leds <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= next_state;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_len != '0) begin
                            index    <= '0;
                            len_q    <= start_len;
                            bus.addr <= '0;
                            bus.busy <= 1'b1;
                        end else begin
                            bus.done <= 1'b1;
                        end
                    end
                end
                LOAD: bus.leds <= bus.bram_data;
                SHOW: if (timer_expired) bus.leds <= '0;
                GAP: begin
                    if (timer_expired) begin
                        if (last_elem) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.addr <= '0;
                        end else begin
                            index    <= index + IDX_W'(1);
                            bus.addr <= ADDR_W'(index + IDX_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_display.sv
// Self-checking bench for sequence_display: table vectors, directed corner
// sequences and randomized playbacks against a timeline model of the display.
module tb_sequence_display;
    import memory_game_pkg::*;

    localparam int S = 4;
    localparam int G = 2;
    localparam int P = 2 + S + G;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sequence_display_if bus ();

    sequence_display #(.SHOW_CYCLES(S), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] mem [16];
    always @(posedge clk) bus.bram_data <= mem[bus.addr];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] leds;
        logic       busy;
        logic       done;
        logic       addr_chk;
        logic [3:0] addr;
    } exp_t;

    typedef struct {
        logic [4:0] length;
        bit         ident;
        int         done_cyc;
        int         busy_cyc;
        int         max_addr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline of one playback started at edge 0: each element takes one
    // period of P cycles (fetch, load, S shown, G blank); done follows the last.
    function automatic exp_t model(input int t, input int len, input int rst_at);
        exp_t e;
        int   lc, k, ph;
        e.leds = '0; e.busy = 1'b0; e.done = 1'b0; e.addr_chk = 1'b1; e.addr = '0;
        if (rst_at >= 0 && t > rst_at) return e;
        lc = (len > MAX_LEN) ? MAX_LEN : len;
        if (lc == 0) begin
            e.done = (t == 1);
            return e;
        end
        e.done = (t == lc * P + 1);
        if (t >= 1 && t <= lc * P) begin
            e.busy     = 1'b1;
            k          = (t - 1) / P;
            ph         = (t - 1) % P;
            e.addr_chk = (ph == 0);
            e.addr     = 4'(k);
            if (ph >= 2 && ph < 2 + S) e.leds = mem[k];
        end
        return e;
    endfunction

    task automatic play(input logic [4:0] len, input int rep_at, input logic [4:0] rep_len,
                        input int rst_at, output int done_cyc, output int busy_cyc,
                        output int max_addr, output int n_done);
        exp_t e;
        int   lc, ncyc;
        lc       = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
        ncyc     = lc * P + 4;
        done_cyc = -1; busy_cyc = 0; max_addr = 0; n_done = 0;
        bus.start  = 1'b1;
        bus.length = len;
        rst        = (rst_at == 0);
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge clk);
            #1;
            e = model(t, int'(len), rst_at);
            check($sformatf("L%0d_c%0d_leds_busy_done", len, t),
                  32'({bus.leds, bus.busy, bus.done}), 32'({e.leds, e.busy, e.done}));
            if (e.addr_chk) check($sformatf("L%0d_c%0d_addr", len, t), 32'(bus.addr), 32'(e.addr));
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = t;
            end
            if (bus.busy) busy_cyc++;
            if (int'(bus.addr) > max_addr) max_addr = int'(bus.addr);
            bus.start  = (t == rep_at);
            bus.length = (t == rep_at) ? rep_len : 5'($urandom);
            rst        = (t == rst_at);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic load_pattern(input bit ident);
        for (int i = 0; i < 16; i++) mem[i] = ident ? 4'(i) : 4'(i * 7 + 1);
        if (!ident) begin
            mem[0] = 4'h3; mem[1] = 4'hA; mem[2] = 4'h5; mem[3] = 4'hF;
        end
    endtask

    vec_t vecs [6];
    int   dc, bc, ma, nd;

    initial begin
        vecs[0] = '{length: 5'd3,  ident: 1'b0, done_cyc: 25,  busy_cyc: 24,  max_addr: 2};
        vecs[1] = '{length: 5'd0,  ident: 1'b0, done_cyc: 1,   busy_cyc: 0,   max_addr: 0};
        vecs[2] = '{length: 5'd1,  ident: 1'b0, done_cyc: 9,   busy_cyc: 8,   max_addr: 0};
        vecs[3] = '{length: 5'd16, ident: 1'b1, done_cyc: 129, busy_cyc: 128, max_addr: 15};
        vecs[4] = '{length: 5'd20, ident: 1'b1, done_cyc: 129, busy_cyc: 128, max_addr: 15};
        vecs[5] = '{length: 5'd31, ident: 1'b1, done_cyc: 129, busy_cyc: 128, max_addr: 15};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.length = '0;
        load_pattern(1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_leds", 32'(bus.leds), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_addr", 32'(bus.addr), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            load_pattern(vecs[i].ident);
            play(vecs[i].length, -1, '0, -1, dc, bc, ma, nd);
            check($sformatf("vec%0d_done_cycle", i), 32'(dc), 32'(vecs[i].done_cyc));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].busy_cyc));
            check($sformatf("vec%0d_max_addr", i), 32'(ma), 32'(vecs[i].max_addr));
            check($sformatf("vec%0d_done_pulses", i), 32'(nd), 32'd1);
        end

        load_pattern(1'b0);
        play(5'd3, 5, 5'd9, -1, dc, bc, ma, nd);
        check("restart_ignored_done_cycle", 32'(dc), 32'd25);
        check("restart_ignored_done_pulses", 32'(nd), 32'd1);

        play(5'd3, -1, '0, 12, dc, bc, ma, nd);
        check("abort_done_pulses", 32'(nd), 32'd0);
        play(5'd2, -1, '0, -1, dc, bc, ma, nd);
        check("replay_done_cycle", 32'(dc), 32'd17);
        check("replay_done_pulses", 32'(nd), 32'd1);

        play(5'd3, -1, '0, 0, dc, bc, ma, nd);
        check("start_with_rst_busy", 32'(bc), 32'd0);
        check("start_with_rst_done", 32'(nd), 32'd0);

        for (int it = 0; it < 12; it++) begin
            int len, lc, rep_at, rst_at, exp_nd;
            len = $urandom_range(0, 31);
            lc  = (len > MAX_LEN) ? MAX_LEN : len;
            for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
            rst_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lc * P + 1) : -1;
            rep_at = (rst_at < 0 && lc > 0 && $urandom_range(0, 1) == 1)
                     ? $urandom_range(1, lc * P) : -1;
            exp_nd = (rst_at < 0 || rst_at > lc * P) ? 1 : 0;
            play(5'(len), rep_at, 5'($urandom), rst_at, dc, bc, ma, nd);
            check($sformatf("rand%0d_done_pulses", it), 32'(nd), 32'(exp_nd));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sequence_display.md
SEQUENCE_DISPLAY -- requirements
Module: sequence_display

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- SHOW_CYCLES, 62_500_000, cycles each element is shown on the LEDs (0.5 s at 125 MHz); legal range 1 to 2^27-1.
- GAP_CYCLES, 12_500_000, blank cycles after each element; legal range 1 to 2^27-1.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock, and rst is synchronous and active-high.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to play the sequence.
- length  in  5  number of elements to show, 0..16.
- bram_data  in  4  data from the sequence BRAM; registered read, 1-cycle latency.
- addr  out  4  BRAM read address.
- leds  out  4  displayed element.
- busy  out  1  high while a playback is in progress.
- done  out  1  one-cycle pulse when a playback completes.

Function
REQ-004 The state machine SHALL use these states: IDLE, FETCH, LOAD, SHOW, GAP.
REQ-005 IDLE behaviour:
- Outputs: addr=0, leds=0, busy=0.
- start=1 with length in 1..16: element index <= 0, next state FETCH, busy=1 from the next cycle.
- start=1 with length=0: done=1 in the next cycle, stay in IDLE, busy stays 0.
- length=17..31 SHALL be treated as 16.
REQ-006 FETCH SHALL last exactly 1 cycle with addr=index[3:0], then go to LOAD.
REQ-007 LOAD SHALL last 1 cycle; at its closing edge, leds <= bram_data and timer <= 0, then go to SHOW.
REQ-008 Start-to-display latency SHALL be 3 cycles: start sampled at edge 0, leds valid from edge 3.
REQ-009 SHOW SHALL hold leds stable for exactly SHOW_CYCLES cycles, then leds <= 0, timer <= 0, next state GAP.
REQ-010 GAP SHALL hold leds=0 for exactly GAP_CYCLES cycles, then:
- If index == length-1: go to IDLE, with done=1 and busy=0 in the first IDLE cycle.
- Otherwise: index <= index+1, go to FETCH.
REQ-011 start SHALL be ignored while busy=1; length SHALL be captured at the accepted start and ignored afterwards.
REQ-012 done SHALL be high for exactly one cycle per accepted start; a pulse for length=0 counts.
REQ-013 The index counter SHALL be 5 bits and never wrap. The last address SHALL be 15 for length=16.
REQ-014 The timer SHALL be 27 bits, compared against PARAM-1, and SHALL never overflow.
REQ-015 All outputs SHALL be registered.

Reset
REQ-016 While rst=1 the block SHALL, at the next edge:
- go to IDLE with addr=0, leds=0, busy=0, done=0, index=0, timer=0;
- ignore start on that edge.
REQ-017 Reset asserted in any state mid-playback SHALL abort the playback with no done pulse.

Structure
REQ-018 Package memory_game_pkg SHALL hold:
- ADDR_W=4, DATA_W=4, MAX_LEN=16;
- the display state enum (IDLE, FETCH, LOAD, SHOW, GAP), shared with feedback and player-input logic.
REQ-019 The dwell counter SHALL be a sub-module, dwell_timer, with:
- ports clk, rst, clear, terminal count input, expired output;
- one instance, reloaded by clear between SHOW and GAP.
REQ-020 The target RTL size is about 150-250 lines including dwell_timer. Instantiation in memory_game_top sits alongside bram_init, sharing the addr mux with address_counter.

Verification (SHOW_CYCLES=4, GAP_CYCLES=2, BRAM model 1-cycle latency, contents 0x3,0xA,0x5,0xF at addresses 0..3)
REQ-021 length=3, start pulse at cycle 0 -> leds shows:
- 0x3 for cycles 3-6, 0 for cycles 7-8;
- 0xA for cycles 11-14 (FETCH/LOAD at 9-10), 0 for 15-16;
- 0x5 for cycles 19-22, 0 for 23-24;
- done=1 at cycle 25 only; busy=1 for cycles 1-24.
REQ-022 length=0, start pulse -> done=1 the next cycle, busy never asserts, leds stay 0.
REQ-023 length=16 with BRAM addr k holding k -> leds shows 0x0..0xF in order; addr never exceeds 15; exactly one done pulse.
REQ-024 start re-pulsed during SHOW, with a different length on the start and length inputs -> ignored; the original sequence completes with one done pulse.
REQ-025 rst=1 for 1 cycle during SHOW of element 1 -> next cycle leds=0, busy=0, addr=0, and done never pulses; a following start with length=2 replays from address 0.
REQ-026 start and rst high on the same edge -> IDLE with busy=0 and no playback.
